// File: rtl/snake_pkg.sv
// Shared definitions for the snake game input path.
//   dir_t          : 2-bit direction code (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//   DIR_CH         : number of button channels that carry a direction
//   opposite_dir() : returns the direction that would reverse the snake
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int DIR_CH = 4;

    // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/dir_input_ctrl_if.sv
// Signal bundle for the direction input controller.
//   btn_i     : raw asynchronous buttons (driven by the board / bench)
//   btn_o     : debounced levels
//   press_o   : one-cycle pulse per accepted press (and per repeat)
//   release_o : one-cycle pulse per accepted release
//   dir_o     : latched direction code
//   dir_chg_o : one-cycle pulse in the cycle dir_o takes a new value
// There is no valid/ready handshake: every *_o pulse is a single-cycle
// event that the consumer must sample in that cycle; levels are held.
// Modports: master = the side that drives the buttons and consumes the
// results; slave = the controller's view.
interface dir_input_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] btn_i;
    logic [NUM_CH-1:0] btn_o;
    logic [NUM_CH-1:0] press_o;
    logic [NUM_CH-1:0] release_o;
    logic [1:0]        dir_o;
    logic              dir_chg_o;

    modport master (
        output btn_i,
        input  btn_o, press_o, release_o, dir_o, dir_chg_o
    );

    modport slave (
        input  btn_i,
        output btn_o, press_o, release_o, dir_o, dir_chg_o
    );
endinterface

// File: rtl/db_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// edge detection and (with DIR_REPEAT_EN defined) auto-repeat while held.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_i      : raw asynchronous button
//   btn_o      : debounced level
//   press_o    : registered pulse on accepted press or repeat
//   release_o  : registered pulse on accepted release
// Optional feature macro: DIR_REPEAT_EN (auto-repeat every RPT_CYCLES).
module db_channel #(
    parameter int DB_CYCLES  = 500000,
    parameter int RPT_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o
);

    localparam int              CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 1 || RPT_CYCLES < 1) begin : g_param_check
        $error("db_channel: DB_CYCLES and RPT_CYCLES must be >= 1");
    end

    logic [1:0]       sync_q;
    logic             synced;
    logic [CNT_W-1:0] db_cnt;
    logic             accept;
    logic             rpt_fire;

    assign synced = sync_q[1];
    // New level is accepted on the DB_CYCLES-th consecutive mismatch.
    assign accept = (synced != btn_o) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            btn_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= (accept && synced) || rpt_fire;
            release_o <= accept && !synced;
            if (synced == btn_o) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt <= '0;
                btn_o  <= synced;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef DIR_REPEAT_EN
    localparam int               RPT_W    = $clog2(RPT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;

    // The counter idles at zero while released, so the first repeat lands
    // exactly RPT_CYCLES after the initial press. A release accepted in the
    // same cycle as a due repeat wins.
    assign rpt_fire = btn_o && !accept && (rpt_cnt == RPT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
        end else if (!btn_o || accept || rpt_fire) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/dir_input_ctrl.sv
// Direction input controller for the snake game: debounces NUM_CH buttons
// and turns presses on ch0..ch3 (up, down, left, right) into a latched
// direction. Channels 4 and above are debounced/edge-detected only.
// Ports:
//   clk, rst_n : game clock, asynchronous active-low reset
//   btn_i      : raw buttons [NUM_CH]
//   btn_o      : debounced levels [NUM_CH]
//   press_o    : press (and repeat) pulses [NUM_CH]
//   release_o  : release pulses [NUM_CH]
//   dir_o      : latched direction, RIGHT after reset
//   dir_chg_o  : pulse in the cycle dir_o changes
// Optional feature macro: DIR_REPEAT_EN (auto-repeat while a button is held).
module dir_input_ctrl
    import snake_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DB_CYCLES  = 500000,
    parameter int RPT_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_i,
    output logic [NUM_CH-1:0] btn_o,
    output logic [NUM_CH-1:0] press_o,
    output logic [NUM_CH-1:0] release_o,
    output logic [1:0]        dir_o,
    output logic              dir_chg_o
);

    if (NUM_CH < DIR_CH) begin : g_num_ch_check
        $error("dir_input_ctrl: NUM_CH must be >= 4");
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        db_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_CYCLES (RPT_CYCLES)
        ) u_db_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_i     (btn_i[gi]),
            .btn_o     (btn_o[gi]),
            .press_o   (press_o[gi]),
            .release_o (release_o[gi])
        );
    end

    dir_t              dir_q;
    dir_t              req_dir;
    logic [DIR_CH-1:0] dir_req;
    logic              take;

    assign dir_req = press_o[DIR_CH-1:0];
    assign dir_o   = dir_q;

    // Only the highest-priority request is considered; if it is rejected
    // (same or opposite direction) lower-priority requests are dropped too.
    always_comb begin
        req_dir = DIR_RIGHT;
        if (dir_req[0])      req_dir = DIR_UP;
        else if (dir_req[1]) req_dir = DIR_DOWN;
        else if (dir_req[2]) req_dir = DIR_LEFT;
        take = (|dir_req) && (req_dir != dir_q) && (req_dir != opposite_dir(dir_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= DIR_RIGHT;
            dir_chg_o <= 1'b0;
        end else begin
            dir_chg_o <= take;
            if (take) begin
                dir_q <= req_dir;
            end
        end
    end

endmodule

// File: tb/tb_dir_input_ctrl.sv
module tb_dir_input_ctrl;

    localparam int NUM_CH = 5;
    localparam int DB     = 8;
    localparam int RPT    = 20;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dir_input_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    dir_input_ctrl #(
        .NUM_CH     (NUM_CH),
        .DB_CYCLES  (DB),
        .RPT_CYCLES (RPT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (bus.btn_i),
        .btn_o     (bus.btn_o),
        .press_o   (bus.press_o),
        .release_o (bus.release_o),
        .dir_o     (bus.dir_o),
        .dir_chg_o (bus.dir_chg_o)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]       cyc;
        logic [NUM_CH-1:0] press;
        logic [NUM_CH-1:0] rel;
        logic              chg;
        logic [1:0]        dir;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // ---------------- reference model ----------------
    // Buttons as seen after two cycles of synchronisation; a level is
    // accepted after DB consecutive disagreeing cycles.
    int                m_cyc = 0;
    logic [NUM_CH-1:0] m_hist[$];
    logic [NUM_CH-1:0] m_level;
    int                m_run[NUM_CH];
    int                m_held[NUM_CH];
    logic [NUM_CH-1:0] m_prev_press;
    logic [1:0]        m_dir;

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
        m_level      = '0;
        m_prev_press = '0;
        m_dir        = 2'd3;
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] seen;
        logic [NUM_CH-1:0] press;
        logic [NUM_CH-1:0] rel;
        logic              chg;
        int                win;
        seen  = m_hist.pop_front();
        m_hist.push_back(bus.btn_i);
        press = '0;
        rel   = '0;
        chg   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (seen[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_level[c] = seen[c];
                    m_run[c]   = 0;
                    if (seen[c]) begin
                        press[c]  = 1'b1;
                        m_held[c] = 0;
                    end else begin
                        rel[c] = 1'b1;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
`ifdef DIR_REPEAT_EN
            if (m_level[c] && !press[c]) begin
                m_held[c]++;
                if (m_held[c] % RPT == 0) press[c] = 1'b1;
            end
`endif
        end
        // Direction from last cycle's presses: lowest channel index wins,
        // and its index is the direction code.
        win = -1;
        for (int c = 3; c >= 0; c--) begin
            if (m_prev_press[c]) win = c;
        end
        if (win >= 0 && win != int'(m_dir) && win != int'(m_dir ^ 2'b01)) begin
            m_dir = 2'(win);
            chg   = 1'b1;
        end
        m_prev_press = press;
        if ((|press) || (|rel) || chg)
            exp_q.push_back('{cyc: 32'(m_cyc), press: press, rel: rel, chg: chg, dir: m_dir});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            m_cyc++;
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    always @(negedge rst_n) begin
        model_reset();
        exp_q.delete();
    end

    // ---------------- monitor ----------------
    initial begin
        ev_t  e;
        logic got_ev;
        forever begin
            @(negedge clk);
            tests++;
            if (bus.btn_o !== m_level) begin
                fails++;
                $display("FAIL btn_o cyc=%0d got=%b exp=%b", m_cyc, bus.btn_o, m_level);
            end
            tests++;
            if (bus.dir_o !== m_dir) begin
                fails++;
                $display("FAIL dir_o cyc=%0d got=%0d exp=%0d", m_cyc, bus.dir_o, m_dir);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < 32'(m_cyc)) begin
                tests++;
                fails++;
                $display("FAIL stale_event cyc=%0d exp_cyc=%0d", m_cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            got_ev = (|bus.press_o) || (|bus.release_o) || bus.dir_chg_o;
            if (got_ev) begin
                tests++;
                if (exp_q.size() == 0 || exp_q[0].cyc != 32'(m_cyc)) begin
                    fails++;
                    $display("FAIL unexpected_event cyc=%0d got press=%b rel=%b chg=%b exp none",
                             m_cyc, bus.press_o, bus.release_o, bus.dir_chg_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.press_o !== e.press || bus.release_o !== e.rel ||
                        bus.dir_chg_o !== e.chg || bus.dir_o !== e.dir) begin
                        fails++;
                        $display("FAIL event cyc=%0d got press=%b rel=%b chg=%b dir=%0d exp press=%b rel=%b chg=%b dir=%0d",
                                 m_cyc, bus.press_o, bus.release_o, bus.dir_chg_o, bus.dir_o,
                                 e.press, e.rel, e.chg, e.dir);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == 32'(m_cyc)) begin
                tests++;
                fails++;
                e = exp_q.pop_front();
                $display("FAIL missing_event cyc=%0d got none exp press=%b rel=%b chg=%b",
                         m_cyc, e.press, e.rel, e.chg);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [NUM_CH-1:0] v, input int n);
        bus.btn_i = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_CH-1:0] v;
        bus.btn_i = '0;
        @(posedge clk);
        #2;
        do_reset(3);

        // Right held from reset: accepted, but same direction -> no change.
        apply(5'b01000, 12);
        apply(5'b00000, 12);

        // Bouncing up for 30 cycles, then a clean hold.
        for (int i = 0; i < 10; i++) apply((i % 2 == 0) ? 5'b00001 : 5'b00000, 3);
        apply(5'b00001, 14);
        apply(5'b00000, 12);

        // From RIGHT: left ignored, down taken.
        do_reset(2);
        apply(5'b00100, 12);
        apply(5'b00000, 12);
        apply(5'b00010, 12);
        apply(5'b00000, 12);

        // Up and left accepted together from RIGHT: up wins.
        do_reset(2);
        apply(5'b00101, 12);
        apply(5'b00000, 12);

        // Reset part-way through a down debounce.
        do_reset(2);
        apply(5'b00000, 4);
        apply(5'b00010, 7);
        do_reset(2);
        apply(5'b00010, 14);
        apply(5'b00000, 12);

`ifdef DIR_REPEAT_EN
        // Generic channel held long enough for two repeats.
        apply(5'b10000, 70);
        apply(5'b00000, 12);
`endif

        // Randomised presses, bounces and combinations.
        for (int s = 0; s < 220; s++) begin
            if (s == 110) do_reset($urandom_range(1, 3));
            v = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            if ($urandom_range(0, 3) == 0) apply(v, $urandom_range(9, 30));
            else                          apply(v, $urandom_range(1, 14));
        end
        apply('0, 16);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
